mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 184 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// Purpose:
//   MEM/WB stage of a simple in-order pipeline. Loads and stores go to a
//   small word-addressed data memory that takes WAIT_CYCLES stall cycles per
//   access. While an access is in flight the stage raises o_freeze so
//   upstream stages hold their inputs stable. The writeback register sees a
//   bubble instead of the instruction until the access completes.
//   Non-memory instructions pass through the writeback register with
//   one-cycle latency.
//
// Parameters:
//   WAIT_CYCLES  cycles o_freeze stays high per memory access (>= 1)
//   DEPTH        number of 32-bit words in data memory (power of two)
//   BASE_ADDR    byte address that maps to word 0
//
// Ports:
//   i_clk         single clock, rising edge
//   i_rst         synchronous, active-high reset
//   i_wb_en       instruction writes a register
//   i_mem_read    load request
//   i_mem_write   store request (wins if both requests are high)
//   i_alu_result  byte address for loads/stores, or ALU result
//   i_val_Rm      store data
//   i_dest        destination register
//   o_freeze      combinational stall request toward upstream stages
//   o_WB_wb_en    registered register-file write enable
//   o_dest_wb     registered destination register
//   o_result_wb   registered writeback data
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int WAIT_CYCLES = 3,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_en,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_val_Rm,
  input  logic [3:0]  i_dest,
  output logic        o_freeze,
  output logic        o_WB_wb_en,
  output logic [3:0]  o_dest_wb,
  output logic [31:0] o_result_wb
);

  // Word-index width; DEPTH is assumed to be a power of two so that slicing
  // the offset gives the modulo-DEPTH wrap for free.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wait counter must be able to hold WAIT_CYCLES-1.
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_CYCLES - 1);
  localparam logic [31:0]   BASE_W    = 32'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;

  logic            w_req;
  logic            w_freeze;
  logic            w_mem_we;
  logic            w_is_load;
  logic [31:0]     w_offset;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_mem_word;
  logic [31:0]     w_wb_data;
  logic            w_unused_off;

  logic [31:0]     r_mem [DEPTH];
  logic            r_wb_en;
  logic [3:0]      r_dest_wb;
  logic [31:0]     r_result_wb;

  // Address decode: byte offset from BASE_ADDR, word-aligned, wrapped to DEPTH.
  assign w_offset     = i_alu_result - BASE_W;
  assign w_idx        = w_offset[AW+1:2];
  // Byte-lane bits and bits above the memory size are intentionally ignored.
  assign w_unused_off = ^{w_offset[31:AW+2], w_offset[1:0]};

  assign w_req      = i_mem_read | i_mem_write;
  // A simultaneous read and write is treated as a store, so no load data.
  assign w_is_load  = i_mem_read & ~i_mem_write;
  assign w_mem_word = r_mem[w_idx];
  assign w_wb_data  = w_is_load ? w_mem_word : i_alu_result;

  // Access sequencer: next state, wait counter, freeze and store strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_freeze    = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          // Stall starts in the very cycle the request appears.
          w_freeze    = 1'b1;
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = (WAIT_CYCLES > 1) ? S_WAIT : S_DONE;
        end else begin
          w_freeze    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        w_freeze  = 1'b1;
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (r_cnt == LAST_WAIT) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        // Freeze drops here so the WB register captures the completed access;
        // the store commits at the end of this single cycle only.
        w_freeze    = 1'b0;
        w_mem_we    = i_mem_write;
        w_cnt_nxt   = CNT_ZERO;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_freeze    = 1'b0;
        w_cnt_nxt   = CNT_ZERO;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer state and wait counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Data memory write port; contents survive reset, and a reset in the
  // DONE cycle suppresses the pending store.
  always_ff @(posedge i_clk) begin
    if (w_mem_we && !i_rst) begin
      r_mem[w_idx] <= i_val_Rm;
    end
  end

  // Writeback register: capture when not frozen, insert a bubble otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wb_en     <= 1'b0;
      r_dest_wb   <= 4'd0;
      r_result_wb <= 32'd0;
    end else if (w_freeze) begin
      r_wb_en     <= 1'b0;
      r_dest_wb   <= r_dest_wb;
      r_result_wb <= r_result_wb;
    end else begin
      r_wb_en     <= i_wb_en;
      r_dest_wb   <= i_dest;
      r_result_wb <= w_wb_data;
    end
  end

  assign o_freeze    = w_freeze;
  assign o_WB_wb_en  = r_wb_en;
  assign o_dest_wb   = r_dest_wb;
  assign o_result_wb = r_result_wb;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Purpose:
//   Directed self-checking bench for mem_wb_stage with WAIT_CYCLES=3,
//   DEPTH=64, BASE_ADDR=1024. Inputs change on the falling edge and outputs
//   are sampled on the falling edge (or 1 time unit after it for the
//   combinational freeze), away from the rising active edge.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int WC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] val_Rm = 32'd0;
  logic [3:0]  dest = 4'd0;
  logic        freeze;
  logic        wb_en_o;
  logic [3:0]  dest_wb;
  logic [31:0] result_wb;

  int n_tests = 0;
  int n_fail  = 0;

  mem_wb_stage #(
    .WAIT_CYCLES(WC),
    .DEPTH(64),
    .BASE_ADDR(1024)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_wb_en(wb_en),
    .i_mem_read(mem_read),
    .i_mem_write(mem_write),
    .i_alu_result(alu_result),
    .i_val_Rm(val_Rm),
    .i_dest(dest),
    .o_freeze(freeze),
    .o_WB_wb_en(wb_en_o),
    .o_dest_wb(dest_wb),
    .o_result_wb(result_wb)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic w, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] ds);
    wb_en      = w;
    mem_read   = rd;
    mem_write  = wr;
    alu_result = a;
    val_Rm     = d;
    dest       = ds;
  endtask

  task automatic set_idle();
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  // Present one memory instruction and hold it through the stall; checks
  // freeze 1,1,1,0 and the writeback bubble while frozen.
  task automatic mem_access(input string tag, input logic w, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] ds);
    for (int k = 0; k <= WC; k++) begin
      @(negedge clk);
      if (k == 0) set_in(w, rd, wr, a, d, ds);
      #1;
      check({tag, " freeze"}, {31'd0, freeze}, (k < WC) ? 32'd1 : 32'd0);
      if (k >= 1) check({tag, " bubble"}, {31'd0, wb_en_o}, 32'd0);
    end
  endtask

  // Check the writeback register one edge later, then go idle.
  task automatic expect_wb(input string tag, input logic en, input logic [3:0] ds,
                           input logic [31:0] res);
    @(negedge clk);
    check({tag, " wb_en"}, {31'd0, wb_en_o}, {31'd0, en});
    check({tag, " dest"}, {28'd0, dest_wb}, {28'd0, ds});
    check({tag, " result"}, result_wb, res);
    set_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst wb_en", {31'd0, wb_en_o}, 32'd0);
    check("rst dest", {28'd0, dest_wb}, 32'd0);
    check("rst result", result_wb, 32'd0);
    rst = 1'b0;
    #1;
    check("rst freeze", {31'd0, freeze}, 32'd0);

    // ALU pass-through, one-cycle latency, no freeze
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 32'h0000_002A, 32'd0, 4'd5);
    #1;
    check("alu1 freeze", {31'd0, freeze}, 32'd0);
    expect_wb("alu1", 1'b1, 4'd5, 32'h0000_002A);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 32'hFFFF_0000, 32'd0, 4'd12);
    #1;
    check("alu2 freeze", {31'd0, freeze}, 32'd0);
    expect_wb("alu2", 1'b0, 4'd12, 32'hFFFF_0000);

    // Store then load word 1
    mem_access("st1", 1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd0);
    expect_wb("st1", 1'b0, 4'd0, 32'd1028);
    mem_access("ld1", 1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd3);
    expect_wb("ld1", 1'b1, 4'd3, 32'hDEAD_BEEF);

    // Address wrap: 1024+256 maps to word 0
    mem_access("stw", 1'b0, 1'b0, 1'b1, 32'd1280, 32'h0000_0011, 4'd0);
    expect_wb("stw", 1'b0, 4'd0, 32'd1280);
    mem_access("ldw", 1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd4);
    expect_wb("ldw", 1'b1, 4'd4, 32'h0000_0011);

    // Read and write together behave as a store; writeback gets alu_result
    mem_access("strw", 1'b1, 1'b1, 1'b1, 32'd1044, 32'h0000_BEEF, 4'd9);
    expect_wb("strw", 1'b1, 4'd9, 32'd1044);
    mem_access("ldrw", 1'b1, 1'b1, 1'b0, 32'd1044, 32'd0, 4'd9);
    expect_wb("ldrw", 1'b1, 4'd9, 32'h0000_BEEF);

    // Reset during WAIT (cycle T+2) aborts the store
    mem_access("stp", 1'b0, 1'b0, 1'b1, 32'd1032, 32'h0000_A5A5, 4'd0);
    expect_wb("stp", 1'b0, 4'd0, 32'd1032);
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b1, 32'd1032, 32'h0000_0055, 4'd8);
    #1;
    check("abw freeze0", {31'd0, freeze}, 32'd1);
    @(negedge clk);
    #1;
    check("abw freeze1", {31'd0, freeze}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    #1;
    check("abw freeze", {31'd0, freeze}, 32'd0);
    check("abw wb_en", {31'd0, wb_en_o}, 32'd0);
    check("abw dest", {28'd0, dest_wb}, 32'd0);
    check("abw result", result_wb, 32'd0);
    mem_access("ldab", 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd2);
    expect_wb("ldab", 1'b1, 4'd2, 32'h0000_A5A5);

    // Reset in the DONE cycle (T+3) also aborts the store
    mem_access("stq", 1'b0, 1'b0, 1'b1, 32'd1036, 32'h0000_1234, 4'd0);
    expect_wb("stq", 1'b0, 4'd0, 32'd1036);
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b1, 32'd1036, 32'h0000_0077, 4'd8);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abd freeze", {31'd0, freeze}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    #1;
    check("abd wb_en", {31'd0, wb_en_o}, 32'd0);
    check("abd result", result_wb, 32'd0);
    mem_access("ldad", 1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd1);
    expect_wb("ldad", 1'b1, 4'd1, 32'h0000_1234);

    // Back-to-back load then store with no idle gap
    for (int k = 0; k < 2 * (WC + 1); k++) begin
      @(negedge clk);
      if (k == 0) set_in(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd7);
      if (k == WC + 1) begin
        check("b2b ld wb_en", {31'd0, wb_en_o}, 32'd1);
        check("b2b ld dest", {28'd0, dest_wb}, 32'd7);
        check("b2b ld result", result_wb, 32'h0000_0011);
        set_in(1'b0, 1'b0, 1'b1, 32'd1040, 32'h0000_CAFE, 4'd0);
      end
      #1;
      check("b2b freeze", {31'd0, freeze}, ((k % (WC + 1)) != WC) ? 32'd1 : 32'd0);
    end
    expect_wb("b2b st", 1'b0, 4'd0, 32'd1040);
    mem_access("ldb2b", 1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, 4'd6);
    expect_wb("ldb2b", 1'b1, 4'd6, 32'h0000_CAFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
